// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache, its memory model and benches.
// Request words are laid out MSB first as {mode, index, tag, data}, where mode 1 means write.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    INSTALL,
    RESPOND
  } cache_state_e;

  localparam int DEF_INDEX_W = 2;
  localparam int DEF_TAG_W   = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int REQ_MODE_W  = 1;

  function automatic int req_width(input int index_w, input int tag_w, input int data_w);
    return REQ_MODE_W + index_w + tag_w + data_w;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// Storage for one cache way: valid/dirty flags (reset) plus tag/data words (not reset).
// A single index serves both the combinational read and the clocked write.
module cache_way_array #(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [INDEX_W-1:0] index_i,
  input  logic              we_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_dirty_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int SETS = 2**INDEX_W;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[index_i]  <= wr_tag_i;
      data_q[index_i] <= wr_data_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative write-back, write-allocate cache with per-set true LRU,
// a req/ack backing-store port and saturating hit/miss counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 8,
  parameter int STAT_W  = 16,
  localparam int ADDR_W = TAG_W + INDEX_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int SETS = 2**INDEX_W;

  cache_state_e state_q, state_d;

  logic               we_q;
  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               hit_q;
  logic               victim_q;
  logic [SETS-1:0]    lru_q;
  logic [STAT_W-1:0]  hit_count_q;
  logic [STAT_W-1:0]  miss_count_q;

  logic [1:0]         way_valid, way_dirty, way_we;
  logic [TAG_W-1:0]   way_tag  [2];
  logic [DATA_W-1:0]  way_data [2];
  logic [DATA_W-1:0]  wr_data;
  logic               wr_dirty;

  logic               hit0, hit1, lookup_hit, hit_way, victim_sel;

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .index_i    (index_q),
      .we_i       (way_we[w]),
      .wr_tag_i   (tag_q),
      .wr_data_i  (wr_data),
      .wr_dirty_i (wr_dirty),
      .valid_o    (way_valid[w]),
      .dirty_o    (way_dirty[w]),
      .tag_o      (way_tag[w]),
      .data_o     (way_data[w])
    );
  end

  assign hit0       = way_valid[0] && (way_tag[0] == tag_q);
  assign hit1       = way_valid[1] && (way_tag[1] == tag_q);
  assign lookup_hit = hit0 || hit1;
  assign hit_way    = hit1;
  // An empty way is always filled first; lru_q names the least recently used way.
  assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[index_q]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (lookup_hit)                                       state_d = RESPOND;
        else if (way_valid[victim_sel] && way_dirty[victim_sel]) state_d = WRITEBACK;
        else if (we_q)                                        state_d = INSTALL;
        else                                                  state_d = REFILL;
      end
      WRITEBACK: if (mem_ack) state_d = we_q ? INSTALL : REFILL;
      REFILL:    if (mem_ack) state_d = INSTALL;
      INSTALL:   state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESPOND);
    resp_hit   = (state_q == RESPOND) && hit_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    way_we     = 2'b00;
    wr_data    = wdata_q;
    wr_dirty   = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (lookup_hit && we_q) begin
          way_we[hit_way] = 1'b1;
          wr_dirty        = 1'b1;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {way_tag[victim_q], index_q};
        mem_wdata = way_data[victim_q];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, index_q};
      end
      INSTALL: begin
        way_we[victim_q] = 1'b1;
        wr_data          = we_q ? wdata_q : rdata_q;
        wr_dirty         = we_q;
      end
      default: ;
    endcase
  end

  // Request latch, response data, LRU and statistics; rdata_q doubles as the refill buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q         <= 1'b0;
      index_q      <= '0;
      tag_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      victim_q     <= 1'b0;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            index_q <= req_index;
            tag_q   <= req_tag;
            wdata_q <= req_wdata;
          end
        end
        LOOKUP: begin
          hit_q <= lookup_hit;
          if (lookup_hit) begin
            lru_q[index_q] <= ~hit_way;
            rdata_q        <= we_q ? wdata_q : way_data[hit_way];
            if (hit_count_q != '1) hit_count_q <= hit_count_q + STAT_W'(1);
          end else begin
            victim_q <= victim_sel;
            if (miss_count_q != '1) miss_count_q <= miss_count_q + STAT_W'(1);
          end
        end
        REFILL:  if (mem_ack) rdata_q <= mem_rdata;
        INSTALL: begin
          lru_q[index_q] <= ~victim_q;
          if (we_q) rdata_q <= wdata_q;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate cache; next generation of the fixed 4-line cache driven by the instruction-stream memory model.
- CPU side: valid/ready request, one-cycle response pulse. Memory side: req/ack handshake to the backing store.
- One data word per line; true-LRU replacement per set; saturating hit and miss counters for performance runs.

Parameters:
- INDEX_W, 2, set index width; number of sets = 2**INDEX_W.
- TAG_W, 8, tag width.
- DATA_W, 8, data word width.
- STAT_W, 16, width of the hit and miss counters.
- Derived: ADDR_W = TAG_W+INDEX_W; address = {tag, index}.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  cache idle; request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_index  in  INDEX_W  set index.
- req_tag  in  TAG_W  tag.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  request hit (qualified by resp_valid).
- resp_rdata  out  DATA_W  read data; on writes, the written data.
- mem_req  out  1  memory access request, held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  ADDR_W  {tag, index}.
- mem_wdata  out  DATA_W  victim data.
- mem_rdata  in  DATA_W  refill data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion.
- hit_count  out  STAT_W  saturating hit counter.
- miss_count  out  STAT_W  saturating miss counter.

Behaviour:
- Reset (async, reset_n=0):
  - All valid bits, dirty bits and LRU bits cleared; FSM to IDLE.
  - req_ready=1; resp_valid, resp_hit, mem_req and mem_we are 0; resp_rdata, mem_addr and mem_wdata are 0; both counters 0.
  - A reset mid-operation abandons the access immediately (mem_req drops) and returns no response.
- Data and tag storage is not reset.
- IDLE: req_ready=1. On handshake, latch we/index/tag/wdata, drop req_ready and go to LOOKUP. req_valid while busy is ignored.
- LOOKUP (compare both ways at the latched index):
  - Hit: read data, or write the way and set dirty; LRU points to the other way; hit_count++. Go to RESPOND with resp_hit=1.
  - Miss: miss_count++. Victim = first invalid way (way0 preferred), else the LRU way.
    - Victim valid & dirty: go to WRITEBACK.
    - Else, write: go to INSTALL.
    - Else, read: go to REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ack: write goes to INSTALL, read goes to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={req tag, index}. On mem_ack, capture mem_rdata and go to INSTALL.
- INSTALL:
  - Write victim way: valid=1, tag=req tag.
  - Data = wdata (dirty=1) on a write, or refill data (dirty=0) on a read.
  - LRU points away from the victim. Go to RESPOND with resp_hit=0.
- RESPOND: resp_valid=1 for exactly one cycle with rdata; return to IDLE (req_ready=1 the next cycle).
- Latency, acceptance edge to resp_valid:
  - Hit: 2 cycles.
  - Miss: 3 + memory wait cycles per memory transaction.
- mem_req and its outputs are stable from assertion until the mem_ack cycle; mem_req deasserts the cycle after mem_ack.
- Counters saturate at 2**STAT_W-1; no wrap.
- Simultaneous events:
  - mem_ack outside WRITEBACK/REFILL is ignored.
  - Write-hit and LRU update take effect in the same cycle.

Decomposition:
- Shared package cache_pkg: FSM state enum (IDLE, LOOKUP, WRITEBACK, REFILL, INSTALL, RESPOND) and the request field layout (mode, index, tag, data order) shared with the memory model and test benches.
- Sub-module cache_way_array: one way's valid/dirty/tag/data storage, indexed read plus write enable, instantiated twice. LRU bits live in the top level.

Test Plan:
- Reset, then read idx 2, tag 0x00 with a memory model that returns 0x5A, ack 3 cycles after mem_req:
  - mem_addr=0x002, mem_we=0.
  - resp_rdata=0x5A, resp_hit=0, miss_count=1.
- Write idx 2, tag 0x00, data 0xFF, then read the same address:
  - Both hit with resp_valid 2 cycles after acceptance; read returns 0xFF.
  - No mem_req; hit_count=2.
- Writes to idx 1 with tags 0x10 (data 0xAA) and 0x20 (data 0xBB), then read tag 0x10, then write tag 0x30:
  - Writeback with mem_we=1, mem_addr=0x081, mem_wdata=0xBB.
  - No refill; a later read of tag 0x30 hits.
- Pull reset_n low while mem_req=1 in REFILL:
  - mem_req=0 and req_ready=1 immediately; no resp_valid.
  - Re-reading the same address misses.
- STAT_W=2, five hits: hit_count stops at 3 and stays there.
- Hold req_valid with a new request during a miss: not accepted until req_ready returns; exactly one response per accepted request, in order.
